bcd_score_counter: RTL and testbench

- Multi-digit BCD up-counting score accumulator.
- Accepts point-award requests of 1..9 points, queues them in a pending counter and applies them one increment per enabled clock, carrying decimal-wise across digits.
- Sits beside the game timer logic. The timer counts BCD down to a terminal count; this block counts score BCD up and signals overflow.
- Its digit outputs drive the on-screen score display directly.

---
 rtl/score_pkg.sv | 28 ++
 rtl/bcd_score_counter_if.sv | 35 +++
 rtl/bcd_digit.sv | 43 ++++
 rtl/bcd_score_counter.sv | 118 +++++++++++
 tb/tb_bcd_score_counter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared types and constants for the BCD score counter slice.
//   bcd_digit_t  : one BCD digit (4 bits)
//   BCD_MAX      : largest legal BCD digit value
//   PEND_W/MAX   : width and saturation value of the pending-points counter
//   state_t      : counter FSM states
//   clamp_award  : maps a raw 4-bit award to 0..9
// -----------------------------------------------------------------------------
package score_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam int PEND_W = 5;
    localparam logic [PEND_W-1:0] PEND_MAX = 5'd31;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    // Awards above 9 are clamped to 9; 0 stays 0 (ignored by the caller).
    function automatic bcd_digit_t clamp_award(input logic [3:0] raw);
        return (raw > BCD_MAX) ? BCD_MAX : raw;
    endfunction

endpackage

// File: rtl/bcd_score_counter_if.sv
// -----------------------------------------------------------------------------
// bcd_score_counter_if
// Control/award inputs and score outputs of the BCD score counter.
//   clearN    : synchronous active-low clear
//   ena       : count-enable tick
//   add_req   : award request
//   add_val   : award amount (0 ignored, >9 clamped)
//   digits    : BCD score, ones digit in [3:0]
//   busy      : pending points remain
//   carry_out : one-cycle wrap pulse
//   full      : all digits are 9
// Modports: master drives requests (game logic / bench), slave is the counter.
// -----------------------------------------------------------------------------
interface bcd_score_counter_if #(
    parameter int DIGITS = 4
);
    logic                  clearN;
    logic                  ena;
    logic                  add_req;
    logic [3:0]            add_val;
    logic [4*DIGITS-1:0]   digits;
    logic                  busy;
    logic                  carry_out;
    logic                  full;

    modport master (
        output clearN, ena, add_req, add_val,
        input  digits, busy, carry_out, full
    );

    modport slave (
        input  clearN, ena, add_req, add_val,
        output digits, busy, carry_out, full
    );
endinterface

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One BCD digit register of the score ripple chain.
//   clk, resetN : clock, asynchronous active-low reset
//   clr         : synchronous clear (priority over inc_in)
//   inc_in      : increment this digit on the current edge
//   digit       : registered digit value 0..9
//   carry       : combinational carry into the next digit (digit==9 && inc_in)
// -----------------------------------------------------------------------------
module bcd_digit
    import score_pkg::*;
(
    input  logic       clk,
    input  logic       resetN,
    input  logic       clr,
    input  logic       inc_in,
    output bcd_digit_t digit,
    output logic       carry
);

    bcd_digit_t digit_r;

    // Digit register: clear wins, otherwise a 9 rolls over to 0 on increment.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            digit_r <= 4'd0;
        end else if (clr) begin
            digit_r <= 4'd0;
        end else if (inc_in) begin
            digit_r <= (digit_r == BCD_MAX) ? 4'd0 : (digit_r + 4'd1);
        end else begin
            digit_r <= digit_r;
        end
    end

    // Carry ripples combinationally so the whole chain updates on one edge.
    always_comb begin
        carry = (digit_r == BCD_MAX) && inc_in;
    end

    assign digit = digit_r;

endmodule

// File: rtl/bcd_score_counter.sv
// -----------------------------------------------------------------------------
// bcd_score_counter
// Multi-digit BCD up-counting score accumulator. Awards of 1..9 points are
// queued in a saturating 5-bit pending counter and applied one point per
// enabled clock, carrying decimal-wise across DIGITS digits.
//   clk     : system clock
//   resetN  : asynchronous active-low reset
//   sb      : bcd_score_counter_if.slave (clearN, ena, add_req, add_val in;
//             digits, busy, carry_out, full out)
// Parameter DIGITS: number of BCD digits, 1..8.
// Build option SCORE_SATURATE_EN: when defined the score sticks at all-9s
// (pending still drains, carry_out never pulses); when undefined the score
// wraps to all-0s with a one-cycle carry_out pulse.
// -----------------------------------------------------------------------------
module bcd_score_counter
    import score_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    resetN,
    bcd_score_counter_if.slave      sb
);

    state_t              state_r;
    state_t              state_next_s;
    logic [PEND_W-1:0]   pend_r;
    logic [PEND_W-1:0]   pend_next_s;
    logic [PEND_W:0]     pend_sum_s;
    logic                busy_r;
    logic                carry_out_r;

    bcd_digit_t          award_s;
    logic                accept_s;
    logic                inc_s;
    logic                full_s;
    logic                wrap_s;
    logic [4*DIGITS-1:0] digits_s;
    logic                chain_s [0:DIGITS];

    // Award clamping and increment qualification.
    always_comb begin
        award_s  = clamp_award(sb.add_val);
        accept_s = sb.add_req && (award_s != 4'd0);
        inc_s    = (state_r == S_COUNT) && sb.ena;
    end

    // Next pending value and FSM next state; clear discards any same-edge award.
    always_comb begin
        pend_sum_s   = {1'b0, pend_r}
                     + {2'b00, (accept_s ? award_s : 4'd0)}
                     - {{PEND_W{1'b0}}, inc_s};
        pend_next_s  = pend_r;
        state_next_s = state_r;
        if (!sb.clearN) begin
            pend_next_s  = {PEND_W{1'b0}};
            state_next_s = S_IDLE;
        end else begin
            pend_next_s = (pend_sum_s > {1'b0, PEND_MAX}) ? PEND_MAX
                                                          : pend_sum_s[PEND_W-1:0];
            case (state_r)
                S_IDLE:  state_next_s = (pend_next_s != {PEND_W{1'b0}}) ? S_COUNT : S_IDLE;
                S_COUNT: state_next_s = (pend_next_s == {PEND_W{1'b0}}) ? S_IDLE : S_COUNT;
                default: state_next_s = S_IDLE;
            endcase
        end
    end

    // State, pending, busy and wrap-pulse registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r     <= S_IDLE;
            pend_r      <= {PEND_W{1'b0}};
            busy_r      <= 1'b0;
            carry_out_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            pend_r      <= pend_next_s;
            busy_r      <= (pend_next_s != {PEND_W{1'b0}});
            carry_out_r <= sb.clearN && wrap_s;
        end
    end

    // Full detect over the registered digits.
    always_comb begin
        full_s = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            full_s = full_s && (digits_s[i*4 +: 4] == BCD_MAX);
        end
    end

`ifdef SCORE_SATURATE_EN
    // Saturating build: increments at all-9s are dropped, so no wrap occurs.
    assign chain_s[0] = inc_s && !full_s;
    assign wrap_s     = 1'b0;
`else
    // Wrapping build: the carry out of the top digit marks the all-9s rollover.
    assign chain_s[0] = inc_s;
    assign wrap_s     = chain_s[DIGITS];
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .resetN (resetN),
            .clr    (!sb.clearN),
            .inc_in (chain_s[g]),
            .digit  (digits_s[g*4 +: 4]),
            .carry  (chain_s[g+1])
        );
    end

    assign sb.digits    = digits_s;
    assign sb.busy      = busy_r;
    assign sb.carry_out = carry_out_r;
    assign sb.full      = full_s;

endmodule

// File: tb/tb_bcd_score_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_score_counter
// Self-checking bench for bcd_score_counter (DIGITS=4). The score is modelled
// as an integer modulo 10^DIGITS and pending as a saturating integer.
// -----------------------------------------------------------------------------
module tb_bcd_score_counter;

    localparam int DIGITS = 4;
    localparam int MAXS   = 9999;

    logic clk = 1'b0;
    logic resetN = 1'b0;

    bcd_score_counter_if #(.DIGITS(DIGITS)) sif ();

    bcd_score_counter #(.DIGITS(DIGITS)) dut (
        .clk    (clk),
        .resetN (resetN),
        .sb     (sif.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int score_m = 0;
    int pend_m = 0;
    bit carry_m = 1'b0;
    logic [18:0] got, exp_v;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Apply inputs, take one clock edge, advance the model, settle 1 time unit.
    task automatic tick(input bit cl, input bit en, input bit rq, input logic [3:0] v);
        int a;
        bit inc;
        sif.clearN  = cl;
        sif.ena     = en;
        sif.add_req = rq;
        sif.add_val = v;
        @(posedge clk);
        if (!cl) begin
            score_m = 0; pend_m = 0; carry_m = 1'b0;
        end else begin
            inc = (pend_m > 0) && en;
            a = rq ? ((int'(v) > 9) ? 9 : int'(v)) : 0;
            carry_m = 1'b0;
            if (inc) begin
`ifdef SCORE_SATURATE_EN
                if (score_m < MAXS) score_m = score_m + 1;
`else
                if (score_m == MAXS) begin score_m = 0; carry_m = 1'b1; end
                else score_m = score_m + 1;
`endif
            end
            pend_m = pend_m - int'(inc) + a;
            if (pend_m > 31) pend_m = 31;
        end
        #1;
    endtask

    // Reach score == target with nothing pending, feeding awards with ena=1.
    task automatic preload(input int target);
        int rem;
        tick(1'b0, 1'b0, 1'b0, 4'd0);
        for (int n = 0; n < 12000 && !(score_m == target && pend_m == 0); n++) begin
            rem = target - score_m - pend_m;
            tick(1'b1, 1'b1, rem > 0, 4'((rem > 9) ? 9 : (rem < 0 ? 0 : rem)));
        end
        checks++;
        if (sif.digits !== to_bcd(target) || sif.busy !== 1'b0) begin
            errors++;
            $display("FAIL preload: digits=%h busy=%b expected digits=%h busy=0", sif.digits, sif.busy, to_bcd(target));
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({sif.digits, sif.busy, sif.carry_out, sif.full} !== 19'd0) begin
            errors++;
            $display("FAIL reset: got=%h expected=0", {sif.digits, sif.busy, sif.carry_out, sif.full});
        end
    endtask

    task automatic test_single_award();
        logic [15:0] ed [4] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
        bit          eb [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        tick(1'b1, 1'b1, 1'b1, 4'd3);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick(1'b1, 1'b1, 1'b0, 4'd0);
            checks++;
            if (sif.digits !== ed[i] || sif.busy !== eb[i] || sif.carry_out !== 1'b0) begin
                errors++;
                $display("FAIL single[%0d]: digits=%h busy=%b expected digits=%h busy=%b", i, sif.digits, sif.busy, ed[i], eb[i]);
            end
        end
    endtask

    task automatic test_decimal_carry();
        logic [15:0] seq [5] = '{16'h0099, 16'h0100, 16'h0101, 16'h0102, 16'h0103};
        preload(98);
        tick(1'b1, 1'b1, 1'b1, 4'd5);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1, 1'b0, 4'd0);
            checks++;
            if (sif.digits !== seq[i] || sif.busy !== (i < 4)) begin
                errors++;
                $display("FAIL carry[%0d]: digits=%h busy=%b expected digits=%h busy=%b", i, sif.digits, sif.busy, seq[i], (i < 4));
            end
        end
    endtask

    task automatic test_queue_clamp();
        tick(1'b0, 1'b0, 1'b0, 4'd0);
        tick(1'b1, 1'b0, 1'b1, 4'd9);
        tick(1'b1, 1'b0, 1'b1, 4'd15);
        tick(1'b1, 1'b0, 1'b0, 4'd0);
        checks++;
        if (sif.digits !== 16'h0000 || sif.busy !== 1'b1 || pend_m != 18) begin
            errors++;
            $display("FAIL queue_hold: digits=%h busy=%b expected digits=0000 busy=1", sif.digits, sif.busy);
        end
        for (int i = 0; i < 18; i++) begin
            tick(1'b1, 1'b1, 1'b0, 4'd0);
            got = {sif.digits, sif.busy, sif.carry_out, sif.full};
            exp_v = {to_bcd(score_m), pend_m != 0, carry_m, score_m == MAXS};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL queue_drain[%0d]: got=%h expected=%h", i, got, exp_v);
            end
        end
        checks++;
        if (sif.digits !== 16'h0018 || sif.busy !== 1'b0) begin
            errors++;
            $display("FAIL queue_end: digits=%h busy=%b expected digits=0018 busy=0", sif.digits, sif.busy);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        tick(1'b0, 1'b0, 1'b0, 4'd0);
        tick(1'b1, 1'b0, 1'b1, 4'd4);
        tick(1'b1, 1'b1, 1'b1, 4'd2);
        n = 0;
        while (sif.busy === 1'b1 && n < 40) begin
            tick(1'b1, 1'b1, 1'b0, 4'd0);
            n++;
        end
        checks++;
        if (n != 5 || sif.digits !== 16'h0006) begin
            errors++;
            $display("FAIL simul_pending: increments=%0d digits=%h expected increments=5 digits=0006", n, sif.digits);
        end
        tick(1'b1, 1'b1, 1'b1, 4'd9);
        tick(1'b1, 1'b1, 1'b0, 4'd0);
        tick(1'b0, 1'b1, 1'b1, 4'd5);
        checks++;
        if (sif.digits !== 16'h0000 || sif.busy !== 1'b0 || sif.carry_out !== 1'b0) begin
            errors++;
            $display("FAIL clear_mid: digits=%h busy=%b expected digits=0000 busy=0", sif.digits, sif.busy);
        end
    endtask

    task automatic test_overflow();
`ifdef SCORE_SATURATE_EN
        logic [15:0] ed [3] = '{16'h9999, 16'h9999, 16'h9999};
        bit          ec [3] = '{1'b0, 1'b0, 1'b0};
        bit          ef [3] = '{1'b1, 1'b1, 1'b1};
`else
        logic [15:0] ed [3] = '{16'h9999, 16'h0000, 16'h0001};
        bit          ec [3] = '{1'b0, 1'b1, 1'b0};
        bit          ef [3] = '{1'b1, 1'b0, 1'b0};
`endif
        preload(9998);
        tick(1'b1, 1'b1, 1'b1, 4'd3);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, 1'b0, 4'd0);
            checks++;
            if (i < 3) begin
                if (sif.digits !== ed[i] || sif.carry_out !== ec[i] || sif.full !== ef[i]) begin
                    errors++;
                    $display("FAIL overflow[%0d]: digits=%h carry=%b full=%b expected %h %b %b", i, sif.digits, sif.carry_out, sif.full, ed[i], ec[i], ef[i]);
                end
            end else begin
                if (sif.carry_out !== 1'b0 || sif.busy !== 1'b0 || sif.digits !== ed[2]) begin
                    errors++;
                    $display("FAIL overflow_after: digits=%h carry=%b busy=%b expected %h 0 0", sif.digits, sif.carry_out, sif.busy, ed[2]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        tick(1'b0, 1'b0, 1'b0, 4'd0);
        tick(1'b1, 1'b1, 1'b1, 4'd9);
        tick(1'b1, 1'b1, 1'b0, 4'd0);
        tick(1'b1, 1'b1, 1'b0, 4'd0);
        #2 resetN = 1'b0;
        #1;
        checks++;
        if ({sif.digits, sif.busy, sif.carry_out} !== 18'd0) begin
            errors++;
            $display("FAIL async_reset: digits=%h busy=%b expected 0000 0", sif.digits, sif.busy);
        end
        score_m = 0; pend_m = 0; carry_m = 1'b0;
        @(posedge clk);
        #1 resetN = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 49) != 0, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            got = {sif.digits, sif.busy, sif.carry_out, sif.full};
            exp_v = {to_bcd(score_m), pend_m != 0, carry_m, score_m == MAXS};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL random[%0d]: got=%h expected=%h", i, got, exp_v);
            end
        end
    endtask

    initial begin
        sif.clearN = 1'b1; sif.ena = 1'b0; sif.add_req = 1'b0; sif.add_val = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        resetN = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single_award();
        test_decimal_carry();
        test_queue_clamp();
        test_simultaneous();
        test_async_reset();
        test_random();
        test_overflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
